// File: rtl/noc_pkg.sv
// Shared NoC definitions: port indices, default router radix, select-width helper
// and the per-output arbiter lock state.
package noc_pkg;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;
  localparam int SOUTH = 3;
  localparam int WEST  = 4;

  localparam int DEFAULT_PORT_N = 5;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width of a port index; a single-port router still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_switch_allocator_if.sv
// Bundle between the input FIFOs / output ports and the switch allocator.
interface rr_switch_allocator_if #(
  parameter int PORT_N = noc_pkg::DEFAULT_PORT_N,
  parameter int SEL_W  = noc_pkg::sel_w(PORT_N)
);

  // Handshakes: an input offers data when ~empty_i[i]; rd_en_o[i] pops it and the
  // flit sits in the holding register (vld_input_o[i]) from the next cycle on.
  // An output accepts when ~full_i[o]; wr_en_o[o] means the flit moves this cycle.
  logic [PORT_N-1:0]       empty_i;
  logic [PORT_N-1:0]       rd_en_o;
  logic [PORT_N-1:0]       vld_input_o;
  logic [PORT_N*SEL_W-1:0] out_sel_i;
  logic [PORT_N-1:0]       tail_i;
  logic [PORT_N-1:0]       full_i;
  logic [PORT_N-1:0]       wr_en_o;
  logic [PORT_N*SEL_W-1:0] mux_in_sel_o;
  logic [PORT_N-1:0]       dbg_lock_o;

  modport slave (
    input  empty_i, out_sel_i, tail_i, full_i,
    output rd_en_o, vld_input_o, wr_en_o, mux_in_sel_o, dbg_lock_o
  );

  modport master (
    output empty_i, out_sel_i, tail_i, full_i,
    input  rd_en_o, vld_input_o, wr_en_o, mux_in_sel_o, dbg_lock_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one output port, with optional wormhole lock that
// keeps the output owned by one input from head flit to tail flit.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int PORT_N      = DEFAULT_PORT_N,
  parameter int SEL_W       = sel_w(PORT_N),
  parameter int PACKET_MODE = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [PORT_N-1:0] req_i,
  input  logic [PORT_N-1:0] tail_i,
  input  logic              full_i,
  output logic [PORT_N-1:0] gnt_o,
  output logic [SEL_W-1:0]  gnt_idx_o,
  output logic              gnt_vld_o,
  output arb_state_e        state_o
);

  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(PORT_N - 1);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] cand;
  logic             gnt_tail;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output logic: round-robin search from ptr+1, overridden by the lock owner.
  always_comb begin
    rr_found  = 1'b0;
    rr_idx    = '0;
    cand      = '0;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int k = 1; k <= PORT_N; k++) begin
      cand = SEL_W'((int'(ptr_q) + k) % PORT_N);
      if (!rr_found && req_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
    if (!full_i) begin
      if (state_q == ARB_LOCKED) begin
        gnt_vld_o = req_i[owner_q];
        gnt_idx_o = owner_q;
      end else begin
        gnt_vld_o = rr_found;
        gnt_idx_o = rr_idx;
      end
    end
    gnt_o   = gnt_vld_o ? (PORT_N'(1) << gnt_idx_o) : '0;
    state_o = state_q;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    gnt_tail = tail_i[gnt_idx_o];
    if (gnt_vld_o) begin
      // In wormhole mode the pointer only moves once the whole packet is through.
      if ((PACKET_MODE == 0) || gnt_tail) begin
        ptr_d = gnt_idx_o;
      end
      if (PACKET_MODE != 0) begin
        case (state_q)
          ARB_IDLE: begin
            if (!gnt_tail) begin
              state_d = ARB_LOCKED;
              owner_d = gnt_idx_o;
            end
          end
          ARB_LOCKED: begin
            if (gnt_tail) state_d = ARB_IDLE;
          end
          default: state_d = ARB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/rr_switch_allocator.sv
// Switch allocator: per-input holding registers fed from the input FIFOs and one
// round-robin arbiter per output, deciding the crossbar setting every cycle.
module rr_switch_allocator
  import noc_pkg::*;
#(
  parameter int PORT_N      = DEFAULT_PORT_N,
  parameter int PACKET_MODE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rr_switch_allocator_if.slave  bus
);

  localparam int SEL_W = sel_w(PORT_N);

  logic [PORT_N-1:0]             vld_q, vld_d;
  logic [PORT_N-1:0][PORT_N-1:0] req;      // req[o][i]
  logic [PORT_N-1:0][PORT_N-1:0] gnt;      // gnt[o][i], one-hot per output
  logic [PORT_N-1:0][SEL_W-1:0]  gnt_idx;
  logic [PORT_N-1:0]             gnt_vld;
  logic [PORT_N-1:0]             granted;
  logic [PORT_N-1:0]             rd_en;
  arb_state_e                    arb_state [PORT_N];

  // An out-of-range destination matches no output, so that flit simply stalls.
  always_comb begin
    req = '0;
    for (int o = 0; o < PORT_N; o++) begin
      for (int i = 0; i < PORT_N; i++) begin
        req[o][i] = vld_q[i] && (bus.out_sel_i[i*SEL_W +: SEL_W] == SEL_W'(o));
      end
    end
  end

  for (genvar o = 0; o < PORT_N; o++) begin : g_out
    rr_arbiter #(
      .PORT_N      (PORT_N),
      .SEL_W       (SEL_W),
      .PACKET_MODE (PACKET_MODE)
    ) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req[o]),
      .tail_i    (bus.tail_i),
      .full_i    (bus.full_i[o]),
      .gnt_o     (gnt[o]),
      .gnt_idx_o (gnt_idx[o]),
      .gnt_vld_o (gnt_vld[o]),
      .state_o   (arb_state[o])
    );
  end

  // Refill a holding register when it is empty or being forwarded this cycle.
  always_comb begin
    granted = '0;
    for (int o = 0; o < PORT_N; o++) begin
      granted = granted | gnt[o];
    end
    rd_en = ~bus.empty_i & (~vld_q | granted);
    vld_d = rd_en | (vld_q & ~granted);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  always_comb begin
    bus.rd_en_o      = rst_ni ? rd_en : '0;
    bus.wr_en_o      = rst_ni ? gnt_vld : '0;
    bus.vld_input_o  = vld_q;
    bus.mux_in_sel_o = '0;
    bus.dbg_lock_o   = '0;
    for (int o = 0; o < PORT_N; o++) begin
      if (rst_ni && gnt_vld[o]) begin
        bus.mux_in_sel_o[o*SEL_W +: SEL_W] = gnt_idx[o];
      end
      bus.dbg_lock_o[o] = (arb_state[o] == ARB_LOCKED);
    end
  end

  a_full_blocks_wr: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.full_i & bus.wr_en_o) == '0);
  a_empty_blocks_rd: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.empty_i & bus.rd_en_o) == '0);
  a_refill_only_when_granted: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (vld_q & bus.rd_en_o & ~granted) == '0);

endmodule

// File: tb/tb_rr_switch_allocator.sv
// Directed vector bench for rr_switch_allocator: one per-flit instance and one
// wormhole instance, both PORT_N=5.
module tb_rr_switch_allocator;

  localparam int N  = 5;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rr_switch_allocator_if #(.PORT_N(N), .SEL_W(SW)) bus0 ();
  rr_switch_allocator_if #(.PORT_N(N), .SEL_W(SW)) bus1 ();

  rr_switch_allocator #(.PORT_N(N), .PACKET_MODE(0)) u_flit (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus0)
  );

  rr_switch_allocator #(.PORT_N(N), .PACKET_MODE(1)) u_pkt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1)
  );

  typedef struct packed {
    logic [4:0]  empty;
    logic [14:0] sel;
    logic [4:0]  tail;
    logic [4:0]  full;
    logic [4:0]  rd;
    logic [4:0]  wr;
    logic [4:0]  vld;
    logic [4:0]  lk;
    logic [14:0] mux;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [34:0] exp_q[$];
  vec_t tbl0[$];
  vec_t tbl1[$];

  function automatic vec_t mk(input logic [4:0] e, input logic [14:0] s, input logic [4:0] t,
                              input logic [4:0] f, input logic [4:0] rd, input logic [4:0] wr,
                              input logic [4:0] vld, input logic [4:0] lk, input logic [14:0] mux);
    vec_t v;
    v.empty = e; v.sel = s; v.tail = t; v.full = f;
    v.rd = rd; v.wr = wr; v.vld = vld; v.lk = lk; v.mux = mux;
    return v;
  endfunction

  function automatic logic [14:0] sel5(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [2:0] d,
                                       input logic [2:0] e);
    return {e, d, c, b, a};
  endfunction

  task automatic chk5(input string what, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", what, act, exp);
    end
  endtask

  task automatic chk15(input string what, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", what, act, exp);
    end
  endtask

  task automatic drive(input int d, input vec_t v);
    if (d == 0) begin
      bus0.empty_i = v.empty; bus0.out_sel_i = v.sel; bus0.tail_i = v.tail; bus0.full_i = v.full;
    end else begin
      bus1.empty_i = v.empty; bus1.out_sel_i = v.sel; bus1.tail_i = v.tail; bus1.full_i = v.full;
    end
  endtask

  // Drive one vector at the falling edge, check the outputs 1 ns later.
  task automatic apply(input int d, input string tag, input vec_t v);
    logic [4:0]  rd, wr, vld, lk;
    logic [14:0] mux;
    logic [34:0] exp;
    @(negedge clk);
    drive(d, v);
    #1;
    if (d == 0) begin
      rd = bus0.rd_en_o; wr = bus0.wr_en_o; vld = bus0.vld_input_o;
      lk = bus0.dbg_lock_o; mux = bus0.mux_in_sel_o;
    end else begin
      rd = bus1.rd_en_o; wr = bus1.wr_en_o; vld = bus1.vld_input_o;
      lk = bus1.dbg_lock_o; mux = bus1.mux_in_sel_o;
    end
    exp_q.push_back({v.rd, v.wr, v.vld, v.lk, v.mux});
    exp = exp_q.pop_front();
    chk5({tag, " rd_en"}, rd, exp[34:30]);
    chk5({tag, " wr_en"}, wr, exp[29:25]);
    chk5({tag, " vld_input"}, vld, exp[24:20]);
    chk5({tag, " lock"}, lk, exp[19:15]);
    chk15({tag, " mux_in_sel"}, mux, exp[14:0]);
    chk5({tag, " full&wr"}, wr & v.full, 5'd0);
    chk5({tag, " empty&rd"}, rd & v.empty, 5'd0);
  endtask

  task automatic chk_reset(input int d, input string tag);
    if (d == 0) begin
      chk5({tag, " rst rd_en"}, bus0.rd_en_o, 5'd0);
      chk5({tag, " rst wr_en"}, bus0.wr_en_o, 5'd0);
      chk5({tag, " rst vld"}, bus0.vld_input_o, 5'd0);
      chk15({tag, " rst mux"}, bus0.mux_in_sel_o, 15'd0);
    end else begin
      chk5({tag, " rst rd_en"}, bus1.rd_en_o, 5'd0);
      chk5({tag, " rst wr_en"}, bus1.wr_en_o, 5'd0);
      chk5({tag, " rst vld"}, bus1.vld_input_o, 5'd0);
      chk5({tag, " rst lock"}, bus1.dbg_lock_o, 5'd0);
      chk15({tag, " rst mux"}, bus1.mux_in_sel_o, 15'd0);
    end
  endtask

  initial begin
    logic [14:0] sb, sd, se, sf, sp, sq;
    vec_t idle;
    sb = sel5(0, 2, 0, 2, 0);
    sd = sel5(1, 0, 3, 0, 0);
    se = sel5(0, 2, 0, 0, 0);
    sf = sel5(0, 0, 7, 0, 0);
    sp = sel5(4, 0, 4, 0, 0);
    sq = sel5(4, 4, 0, 0, 0);
    idle = mk(5'h1F, 15'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 15'd0);

    // Per-flit sequence: idle, 1/3 contending for out 2, drain, three parallel
    // streams, back-pressure on out 2, out-of-range destination.
    tbl0.push_back(idle);
    tbl0.push_back(idle);
    tbl0.push_back(mk(5'h15, sb, 0, 0, 5'h0A, 5'h00, 5'h00, 0, 15'h000));
    for (int k = 0; k < 2; k++) begin
      tbl0.push_back(mk(5'h15, sb, 0, 0, 5'h02, 5'h04, 5'h0A, 0, 15'h040));
      tbl0.push_back(mk(5'h15, sb, 0, 0, 5'h08, 5'h04, 5'h0A, 0, 15'h0C0));
    end
    tbl0.push_back(mk(5'h1F, sb, 0, 0, 5'h00, 5'h04, 5'h0A, 0, 15'h040));
    tbl0.push_back(mk(5'h1F, sb, 0, 0, 5'h00, 5'h04, 5'h08, 0, 15'h0C0));
    tbl0.push_back(mk(5'h1F, sb, 0, 0, 5'h00, 5'h00, 5'h00, 0, 15'h000));
    tbl0.push_back(mk(5'h0A, sd, 0, 0, 5'h15, 5'h00, 5'h00, 0, 15'h000));
    tbl0.push_back(mk(5'h0A, sd, 0, 0, 5'h15, 5'h0B, 5'h15, 0, 15'h404));
    tbl0.push_back(mk(5'h0A, sd, 0, 0, 5'h15, 5'h0B, 5'h15, 0, 15'h404));
    tbl0.push_back(mk(5'h1F, sd, 0, 0, 5'h00, 5'h0B, 5'h15, 0, 15'h404));
    tbl0.push_back(mk(5'h1F, sd, 0, 0, 5'h00, 5'h00, 5'h00, 0, 15'h000));
    tbl0.push_back(mk(5'h1D, se, 0, 5'h04, 5'h02, 5'h00, 5'h00, 0, 15'h000));
    for (int k = 0; k < 4; k++)
      tbl0.push_back(mk(5'h1D, se, 0, 5'h04, 5'h00, 5'h00, 5'h02, 0, 15'h000));
    tbl0.push_back(mk(5'h1D, se, 0, 0, 5'h02, 5'h04, 5'h02, 0, 15'h040));
    tbl0.push_back(mk(5'h1F, se, 0, 0, 5'h00, 5'h04, 5'h02, 0, 15'h040));
    tbl0.push_back(mk(5'h1F, se, 0, 0, 5'h00, 5'h00, 5'h00, 0, 15'h000));
    tbl0.push_back(mk(5'h1B, sf, 0, 0, 5'h04, 5'h00, 5'h00, 0, 15'h000));
    for (int k = 0; k < 3; k++)
      tbl0.push_back(mk(5'h1F, sf, 0, 0, 5'h00, 5'h00, 5'h04, 0, 15'h000));
    tbl0.push_back(mk(5'h1F, 15'd0, 0, 0, 5'h00, 5'h01, 5'h04, 0, 15'h002));
    tbl0.push_back(idle);

    // Wormhole: 3-flit packet 0->4 against single flit 2->4, then a lock
    // that survives an owner bubble and beats the round-robin order.
    tbl1.push_back(mk(5'h1A, sp, 5'h00, 0, 5'h05, 5'h00, 5'h00, 5'h00, 15'h0000));
    tbl1.push_back(mk(5'h1E, sp, 5'h04, 0, 5'h01, 5'h10, 5'h05, 5'h00, 15'h0000));
    tbl1.push_back(mk(5'h1E, sp, 5'h04, 0, 5'h01, 5'h10, 5'h05, 5'h10, 15'h0000));
    tbl1.push_back(mk(5'h1F, sp, 5'h05, 0, 5'h00, 5'h10, 5'h05, 5'h10, 15'h0000));
    tbl1.push_back(mk(5'h1F, sp, 5'h04, 0, 5'h00, 5'h10, 5'h04, 5'h00, 15'h2000));
    tbl1.push_back(idle);
    tbl1.push_back(mk(5'h1D, sq, 5'h00, 0, 5'h02, 5'h00, 5'h00, 5'h00, 15'h0000));
    tbl1.push_back(mk(5'h1E, sq, 5'h00, 0, 5'h01, 5'h10, 5'h02, 5'h00, 15'h1000));
    tbl1.push_back(mk(5'h1D, sq, 5'h01, 0, 5'h02, 5'h00, 5'h01, 5'h10, 15'h0000));
    tbl1.push_back(mk(5'h1F, sq, 5'h03, 0, 5'h00, 5'h10, 5'h03, 5'h10, 15'h1000));
    tbl1.push_back(mk(5'h1F, sq, 5'h01, 0, 5'h00, 5'h10, 5'h01, 5'h00, 15'h0000));
    tbl1.push_back(idle);

    drive(0, idle);
    drive(1, idle);
    bus0.empty_i = '0;
    bus1.empty_i = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk_reset(0, $sformatf("init%0d flit", k));
      chk_reset(1, $sformatf("init%0d pkt", k));
    end
    bus0.empty_i = '1;
    bus1.empty_i = '1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl0.size(); k++) apply(0, $sformatf("flit v%0d", k), tbl0[k]);
    for (int k = 0; k < tbl1.size(); k++) apply(1, $sformatf("pkt v%0d", k), tbl1[k]);

    // Reset in the middle of a locked packet: lock and held flit are dropped.
    apply(1, "mid R0", mk(5'h1D, sq, 5'h00, 0, 5'h02, 5'h00, 5'h00, 5'h00, 15'h0000));
    apply(1, "mid R1", mk(5'h1D, sq, 5'h00, 0, 5'h02, 5'h10, 5'h02, 5'h00, 15'h1000));
    rst_n = 1'b0;
    #1;
    chk_reset(1, "mid");
    bus1.empty_i = '1;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, "mid R2", mk(5'h1E, sq, 5'h00, 0, 5'h01, 5'h00, 5'h00, 5'h00, 15'h0000));
    apply(1, "mid R3", mk(5'h1F, sq, 5'h01, 0, 5'h00, 5'h10, 5'h01, 5'h00, 15'h0000));
    apply(1, "mid R4", idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_switch_allocator.md
RR_SWITCH_ALLOCATOR -- requirements
Module: rr_switch_allocator

Interface
REQ-001 Parameter PORT_N, default 5: number of router ports (inputs = outputs); SEL_W = max(1, clog2(PORT_N)).
REQ-002 Parameter PACKET_MODE, default 0: 0 = per-flit arbitration; 1 = wormhole, output locked from head grant until tail grant.
REQ-003 clk_i  input  1  clock, rising-edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 empty_i  input  PORT_N  input FIFO i empty.
REQ-006 rd_en_o  output  PORT_N  pop input FIFO i; data valid in holding register next cycle.
REQ-007 vld_input_o  output  PORT_N  holding register of input i holds a flit.
REQ-008 out_sel_i  input  PORT_N*SEL_W  requested output of held flit i, slice [i*SEL_W +: SEL_W]; meaningful only while vld_input_o[i].
REQ-009 tail_i  input  PORT_N  held flit i is last of its packet; ignored when PACKET_MODE=0.
REQ-010 full_i  input  PORT_N  output port o cannot accept a flit.
REQ-011 wr_en_o  output  PORT_N  flit transferred to output o this cycle.
REQ-012 mux_in_sel_o  output  PORT_N*SEL_W  per output o, index of input driving it; valid when wr_en_o[o], 0 otherwise.

Function
REQ-013 Request: req[o][i] = vld[i] and out_sel[i]==o; out_sel[i] >= PORT_N raises no request (flit stalls).
REQ-014 Each output arbitrates independently, round-robin: search starts at ptr[o]+1 modulo PORT_N, first requesting input wins.
REQ-015 Grant to output o only when full_i[o]=0; wr_en_o[o] = grant exists; all outputs may fire in the same cycle.
REQ-016 wr_en_o, mux_in_sel_o, rd_en_o are combinational from current state and inputs (zero-cycle decision).
REQ-017 On grant of input i: vld[i] cleared at next edge unless refilled same cycle.
REQ-018 rd_en_o[i] = ~empty_i[i] and (~vld[i] or granted[i]); read-while-forward gives one flit/cycle/input throughput.
REQ-019 vld[i] next = rd_en_o[i] or (vld[i] and not granted[i]).
REQ-020 ptr[o] <= granted index on wr_en_o[o] when PACKET_MODE=0, or when PACKET_MODE=1 and tail_i of granted input =1; otherwise unchanged.
REQ-021 PACKET_MODE=1: grant of non-tail flit sets lock[o] and owner[o]=i; while locked only owner may be granted, other requests wait.
REQ-022 Lock released at the edge after owner's tail flit is granted; single-flit packet (head=tail) never locks.
REQ-023 Locked output with owner not valid or full_i high: wr_en_o[o]=0, lock held.
REQ-024 Full asserted mid-packet: transfer stalls, vld kept, no flit dropped or duplicated.
REQ-025 Invariants: vld[i] and rd_en_o[i] both high only when granted[i]; full_i[o] implies ~wr_en_o[o]; empty_i[i] implies ~rd_en_o[i]; at most one output grants a given input.

Reset
REQ-026 Asynchronous reset clears vld to 0, all locks to 0, owner to 0, ptr[o] to PORT_N-1 (input 0 highest priority first).
REQ-027 During reset: rd_en_o=0, wr_en_o=0, mux_in_sel_o=0, vld_input_o=0.
REQ-028 Reset mid-packet drops locks and held flits; no recovery state retained.

Structure
REQ-029 Shared package noc_pkg holds port-index constants (LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4), default PORT_N, SEL_W function.
REQ-030 One sub-module rr_arbiter (PORT_N requests, lock/owner, pointer, one-hot grant + index) instantiated per output.

Verification
REQ-031 Reset, all empty_i=1 -> rd_en_o=0, wr_en_o=0, vld_input_o=0 for every cycle.
REQ-032 PORT_N=5, inputs 1 and 3 both hold flits for output 2, full_i=0, streams continuous -> grants alternate 1,3,1,3; mux_in_sel_o[2] alternates; one flit per cycle on output 2.
REQ-033 Inputs 0->1, 2->3, 4->0 simultaneously -> wr_en_o=5'b01011 same cycle, each input refilled via rd_en_o same cycle.
REQ-034 full_i[2]=1 for 4 cycles with input 1 requesting -> wr_en_o[2]=0, vld_input_o[1]=1, rd_en_o[1]=0; on release one transfer, no loss.
REQ-035 PACKET_MODE=1, input 0 sends 3-flit packet to output 4 while input 2 requests output 4 -> all 3 flits of input 0 granted consecutively, input 2 granted next cycle after tail.
REQ-036 out_sel_i[i]=7 with PORT_N=5 -> no wr_en_o, vld_input_o[i] held at 1.
